// File: rtl/result_slot_allocator.sv
// ============================================================================
// result_slot_allocator: rotates sniffer result writes through NUM_SLOTS
// fixed-size slots, tracking occupancy and stalling the writer when full.
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_slot_allocator #(
  parameter int                NUM_SLOTS   = 5,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_W-1:0] SLOT_STRIDE = ADDR_W'(1550),
  localparam int               CNT_W       = $clog2(NUM_SLOTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_addr,
  input  logic              release_slot,
  output logic [ADDR_W-1:0] addr_out,
  output logic              write_enable,
  output logic              full,
  output logic [CNT_W-1:0]  slots_used,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_SLOTS);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2,
    STALL  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [ADDR_W-1:0] slot_addr, slot_addr_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              commit;
  logic              rel_ok;

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    cnt_nxt       = slots_used;
    slot_addr_nxt = slot_addr;
    addr_nxt      = addr_out;
    commit        = (state == ACTIVE) && inc_addr;
    rel_ok        = release_slot && (slots_used != '0);

    // slot_addr shadows wr_ptr incrementally, avoiding a multiplier
    if (commit) begin
      if (wr_ptr == LAST_PTR) begin
        wr_ptr_nxt    = '0;
        slot_addr_nxt = BASE_ADDR;
      end else begin
        wr_ptr_nxt    = wr_ptr + 1'b1;
        slot_addr_nxt = slot_addr + SLOT_STRIDE;
      end
    end

    if (rel_ok) begin
      rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end

    if (commit && !rel_ok) begin
      cnt_nxt = slots_used + 1'b1;
    end else if (!commit && rel_ok) begin
      cnt_nxt = slots_used - 1'b1;
    end

    case (state)
      BOOT:    state_nxt = ARM;
      ARM:     state_nxt = ACTIVE;
      ACTIVE:  if (commit) state_nxt = (cnt_nxt < FULL_CNT) ? ARM : STALL;
      STALL:   if (cnt_nxt < FULL_CNT) state_nxt = ARM;
      default: state_nxt = BOOT;
    endcase

    // addr_out only moves when a slot is armed; it holds through ACTIVE/STALL
    if (state_nxt == ARM) begin
      addr_nxt = slot_addr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      slot_addr    <= BASE_ADDR;
      addr_out     <= BASE_ADDR;
      write_enable <= 1'b0;
      full         <= 1'b0;
      slots_used   <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      slot_addr    <= slot_addr_nxt;
      addr_out     <= addr_nxt;
      write_enable <= (state_nxt == ARM);
      full         <= (cnt_nxt == FULL_CNT);
      slots_used   <= cnt_nxt;
      if (inc_addr && (state != ACTIVE)) overflow <= 1'b1;
      if (release_slot && (slots_used == '0)) underflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire
